// File: rtl/cpu_mem_arbiter_if.sv
// Bus bundle between the cache requesters, the arbiter and the external memory port.
// The slave modport is the arbiter's view; master is the view of the surrounding system.
interface cpu_mem_arbiter_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_PORTS-1:0]                  req_valid;
    logic [NUM_PORTS-1:0]                  req_ready;
    logic [NUM_PORTS-1:0]                  req_write;
    logic [NUM_PORTS*ADDR_WIDTH-1:0]       req_addr;
    logic [NUM_PORTS*DATA_WIDTH-1:0]       req_wdata;
    logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]   req_byteen;
    logic [NUM_PORTS-1:0]                  rsp_valid;
    logic [DATA_WIDTH-1:0]                 rsp_rdata;
    logic                                  mem_req_valid;
    logic                                  mem_req_ready;
    logic                                  mem_req_write;
    logic [ADDR_WIDTH-1:0]                 mem_req_addr;
    logic [DATA_WIDTH-1:0]                 mem_req_wdata;
    logic [DATA_WIDTH/8-1:0]               mem_req_byteen;
    logic                                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0]                 mem_rsp_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_byteen,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        output req_ready, rsp_valid, rsp_rdata,
        output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, mem_req_byteen
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_byteen,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        input  req_ready, rsp_valid, rsp_rdata,
        input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, mem_req_byteen
    );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// N-port arbiter sharing one memory port; one transaction in flight, round-robin or
// fixed priority, completion pulse routed back to the port that issued the request.
module cpu_mem_arbiter #(
    parameter int NUM_PORTS     = 2,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int PRIORITY_MODE = 0
) (
    input  logic             clock,
    input  logic             reset,
    cpu_mem_arbiter_if.slave bus,
    output logic             busy,
    output logic             err_spurious
);
    localparam int unsigned NP    = NUM_PORTS;
    localparam int          IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int          BE_W  = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [IDX_W-1:0]      r_last_grant;
    logic [IDX_W-1:0]      r_owner;
    logic [IDX_W-1:0]      w_winner;
    logic [IDX_W-1:0]      w_cand;
    logic                  w_found;
    logic                  w_accept;
    logic [NUM_PORTS-1:0]  w_req_ready;
    logic [NUM_PORTS-1:0]  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_mem_write;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [BE_W-1:0]       r_mem_be;
    logic                  w_sel_write;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic [BE_W-1:0]       w_sel_be;
    logic                  r_err;

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        if (PRIORITY_MODE != 0) begin
            for (int unsigned i = 0; i < NP; i++) begin
                if (!w_found && bus.req_valid[i]) begin
                    w_found  = 1'b1;
                    w_winner = IDX_W'(i);
                end
            end
        end else begin
            // Scan begins one past the previous grant, so every port is reached within NP accepts
            for (int unsigned k = 1; k <= NP; k++) begin
                w_cand = IDX_W'((32'(r_last_grant) + k) % NP);
                if (!w_found && bus.req_valid[w_cand]) begin
                    w_found  = 1'b1;
                    w_winner = w_cand;
                end
            end
        end
    end

    always_comb begin
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_be    = '0;
        for (int unsigned i = 0; i < NP; i++) begin
            if (IDX_W'(i) == w_winner) begin
                w_sel_write = bus.req_write[i];
                w_sel_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_be    = bus.req_byteen[i*BE_W +: BE_W];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_req_ready  = '0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_accept     = 1'b1;
                    w_next_state = ISSUE;
                    if (!reset) begin
                        w_req_ready[w_winner] = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (bus.mem_req_ready) begin
                    w_next_state = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (bus.mem_rsp_valid) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant <= IDX_W'(NP - 1);
            r_owner      <= '0;
            r_rsp_valid  <= '0;
            r_rsp_rdata  <= '0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_be     <= '0;
            r_err        <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            if (w_accept) begin
                r_last_grant <= w_winner;
                r_owner      <= w_winner;
                r_mem_write  <= w_sel_write;
                r_mem_addr   <= w_sel_addr;
                r_mem_wdata  <= w_sel_wdata;
                r_mem_be     <= w_sel_be;
            end
            if (bus.mem_rsp_valid) begin
                if (r_state == WAIT_RSP) begin
                    r_rsp_valid[r_owner] <= 1'b1;
                    r_rsp_rdata          <= bus.mem_rsp_rdata;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign bus.req_ready      = w_req_ready;
    assign bus.rsp_valid      = r_rsp_valid;
    assign bus.rsp_rdata      = r_rsp_rdata;
    assign bus.mem_req_valid  = (r_state == ISSUE);
    assign bus.mem_req_write  = r_mem_write;
    assign bus.mem_req_addr   = r_mem_addr;
    assign bus.mem_req_wdata  = r_mem_wdata;
    assign bus.mem_req_byteen = r_mem_be;
    assign busy               = (r_state != IDLE);
    assign err_spurious       = r_err;
endmodule
